// File: rtl/ddr3_init_loader_if.sv
// Command/write-data channel between the DDR3 init loader and the ddr3_rw front end.
// The loader drives commands and data through the master modport; the front end uses slave.
interface ddr3_init_loader_if #(
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned UI_WIDTH   = 512
);
  logic                  ddr_start;
  logic                  ddr_rdy;
  logic                  ddr_wdf_data_rdy;
  logic                  ddr_wr_finish;
  logic [2:0]            ddr_cmd;
  logic                  ddr_cmd_valid;
  logic [ADDR_WIDTH-1:0] ddr_base_addr;
  logic [9:0]            ddr_size;
  logic [UI_WIDTH-1:0]   ddr_wdf_data;
  logic                  ddr_wdf_data_valid;
  logic                  init_done;

  modport master (
    input  ddr_start, ddr_rdy, ddr_wdf_data_rdy, ddr_wr_finish,
    output ddr_cmd, ddr_cmd_valid, ddr_base_addr, ddr_size,
           ddr_wdf_data, ddr_wdf_data_valid, init_done
  );

  modport slave (
    output ddr_start, ddr_rdy, ddr_wdf_data_rdy, ddr_wr_finish,
    input  ddr_cmd, ddr_cmd_valid, ddr_base_addr, ddr_size,
           ddr_wdf_data, ddr_wdf_data_valid, init_done
  );
endinterface

// File: rtl/ddr3_init_loader.sv
// Preloads DDR3 with INIT_WORDS UI words in bursts after calibration, then raises
// a sticky init_done so the port can be handed to the conv engine.
module ddr3_init_loader #(
  parameter int unsigned DDR_WIDTH  = 64,
  parameter int unsigned UI_WIDTH   = DDR_WIDTH * 8,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned INIT_WORDS = 4096,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned BASE_ADDR  = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic                   ui_clk,
  input  logic                   rst_n,
  ddr3_init_loader_if.master     bus
);
  localparam int unsigned IDX_W  = $clog2(INIT_WORDS + 1);
  localparam int unsigned REPS   = UI_WIDTH / 32;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_WAIT_FIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc, rd_idx;
  logic [9:0]            beat_q, beat_d;
  logic                  fin_q, fin_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, burst_addr;
  logic [9:0]            size_q, size_d, burst_size;
  logic [UI_WIDTH-1:0]   data_q, data_d, rd_word;
  logic                  dvalid_q, dvalid_d;
  logic                  done_q, done_d;
  logic [31:0]           remain;

  // Word fetched on a register edge: the current index when a burst opens, the next one mid-burst.
  assign idx_inc = idx_q + IDX_W'(1);
  assign rd_idx  = (state_q == S_DATA && 32'(idx_inc) < INIT_WORDS) ? idx_inc : idx_q;

  assign rd_word = UI_WIDTH'({REPS{32'(rd_idx)}});

  assign remain     = INIT_WORDS - 32'(idx_q);
  assign burst_size = 10'((remain < BURST_LEN) ? remain : BURST_LEN);
  assign burst_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      beat_q      <= '0;
      fin_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      dvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      fin_q       <= fin_d;
      cmd_valid_q <= cmd_valid_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      data_q      <= data_d;
      dvalid_q    <= dvalid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    fin_d       = fin_q;
    cmd_valid_d = cmd_valid_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    dvalid_d    = dvalid_q;
    done_d      = done_q;

    // Finish pulses may land while data is still streaming; keep them.
    if ((state_q == S_DATA || state_q == S_WAIT_FIN) && bus.ddr_wr_finish) fin_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ddr_start) begin
          state_d     = S_CMD;
          cmd_valid_d = 1'b1;
          addr_d      = burst_addr;
          size_d      = burst_size;
        end
      end
      S_CMD: begin
        if (bus.ddr_rdy && cmd_valid_q) begin
          state_d     = S_DATA;
          cmd_valid_d = 1'b0;
          dvalid_d    = 1'b1;
          data_d      = rd_word;
          beat_d      = '0;
          fin_d       = bus.ddr_wr_finish;
        end
      end
      S_DATA: begin
        if (bus.ddr_wdf_data_rdy && dvalid_q) begin
          idx_d = idx_inc;
          if (beat_q == size_q - 10'd1) begin
            state_d  = S_WAIT_FIN;
            dvalid_d = 1'b0;
          end else begin
            beat_d = beat_q + 10'd1;
            data_d = rd_word;
          end
        end
      end
      S_WAIT_FIN: begin
        if (fin_q) begin
          if (32'(idx_q) < INIT_WORDS) begin
            state_d     = S_CMD;
            cmd_valid_d = 1'b1;
            addr_d      = burst_addr;
            size_d      = burst_size;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ddr_cmd            = 3'b000;
  assign bus.ddr_cmd_valid      = cmd_valid_q;
  assign bus.ddr_base_addr      = addr_q;
  assign bus.ddr_size           = size_q;
  assign bus.ddr_wdf_data       = data_q;
  assign bus.ddr_wdf_data_valid = dvalid_q;
  assign bus.init_done          = done_q;
endmodule

// File: tb/tb_ddr3_init_loader.sv
// Bench for ddr3_init_loader: randomized front-end responder plus a burst/word reference model.
module tb_ddr3_init_loader;
  localparam int unsigned AW   = 29;
  localparam int unsigned UW   = 512;
  localparam int unsigned NW   = 600;
  localparam int unsigned BL   = 256;
  localparam int unsigned BASE = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ddr3_init_loader_if #(.ADDR_WIDTH(AW), .UI_WIDTH(UW)) bus ();

  ddr3_init_loader #(
    .DDR_WIDTH(64), .UI_WIDTH(UW), .ADDR_WIDTH(AW), .INIT_WORDS(NW),
    .BURST_LEN(BL), .BASE_ADDR(BASE), .INIT_FILE("")
  ) dut (
    .ui_clk(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct { longint addr; longint size; } cmd_t;
  cmd_t            cmd_q[$];
  logic [UW-1:0]   dat_q[$];

  // Responder modes: rdy 0=always 1, 1=random, 2=held low; wdf 0=always 1, 1=toggle, 2=random.
  int rdy_mode = 0, wdf_mode = 0, fin_delay = 3, fin_rand = 0;
  int beats_left = 0, fin_cnt = 0, valid_cycles = 0;
  bit cmd_pend = 0, dat_pend = 0;
  longint p_addr, p_size;
  logic [UW-1:0] p_data;

  always @(negedge clk) begin
    logic rdy, wrdy, fin;
    if (!rst_n) begin
      beats_left = 0; fin_cnt = 0; cmd_pend = 0; dat_pend = 0;
      bus.ddr_rdy = 1'b0; bus.ddr_wdf_data_rdy = 1'b0; bus.ddr_wr_finish = 1'b0;
    end else begin
      fin = 1'b0;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) fin = 1'b1;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b0;
      endcase
      case (wdf_mode)
        0:       wrdy = 1'b1;
        1:       wrdy = ~bus.ddr_wdf_data_rdy;
        default: wrdy = 1'($urandom_range(0, 1));
      endcase

      if (bus.ddr_cmd_valid || bus.ddr_wdf_data_valid) begin
        valid_cycles++;
        chk("cmd_and_data_valid_overlap", longint'(bus.ddr_cmd_valid & bus.ddr_wdf_data_valid), 0);
      end
      if (cmd_pend) begin
        chk("cmd_valid_held", longint'(bus.ddr_cmd_valid), 1);
        chk("cmd_addr_held", longint'(bus.ddr_base_addr), p_addr);
        chk("cmd_size_held", longint'(bus.ddr_size), p_size);
      end
      if (dat_pend) begin
        chk("wdf_valid_held", longint'(bus.ddr_wdf_data_valid), 1);
        chk_w("wdf_data_held", bus.ddr_wdf_data, p_data);
      end

      if (bus.ddr_cmd_valid && rdy) begin
        cmd_q.push_back('{longint'(bus.ddr_base_addr), longint'(bus.ddr_size)});
        beats_left = int'(bus.ddr_size);
        chk("cmd_code", longint'(bus.ddr_cmd), 0);
      end
      cmd_pend = bus.ddr_cmd_valid && !rdy;
      p_addr   = longint'(bus.ddr_base_addr);
      p_size   = longint'(bus.ddr_size);

      if (bus.ddr_wdf_data_valid && wrdy) begin
        dat_q.push_back(bus.ddr_wdf_data);
        beats_left--;
        if (beats_left == 0) begin
          int d;
          d = fin_rand ? int'($urandom_range(0, 4)) : fin_delay;
          if (d == 0) fin = 1'b1;
          else fin_cnt = d;
        end
      end
      dat_pend = bus.ddr_wdf_data_valid && !wrdy;
      p_data   = bus.ddr_wdf_data;

      if (fin) chk("init_done_before_finish", longint'(bus.init_done), 0);
      bus.ddr_rdy          = rdy;
      bus.ddr_wdf_data_rdy = wrdy;
      bus.ddr_wr_finish    = fin;
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int maxc);
    for (int k = 0; k < maxc && bus.init_done !== 1'b1; k++) step(1);
    chk("init_done_timeout", longint'(bus.init_done), 1);
  endtask

  // Reference: bursts of at most BL words from BASE, word i = 32-bit i replicated.
  task automatic check_run(input string tag);
    int n = 0;
    for (int a = 0; a < int'(NW); a += int'(BL)) begin
      longint esz;
      esz = (NW - a < BL) ? longint'(NW - a) : longint'(BL);
      if (n < cmd_q.size()) begin
        chk({tag, "_cmd_addr"}, cmd_q[n].addr, longint'(BASE + a));
        chk({tag, "_cmd_size"}, cmd_q[n].size, esz);
      end
      n++;
    end
    chk({tag, "_cmd_count"}, longint'(cmd_q.size()), longint'(n));
    chk({tag, "_beat_count"}, longint'(dat_q.size()), longint'(NW));
    for (int i = 0; i < int'(NW) && i < dat_q.size(); i++)
      chk_w({tag, "_word"}, dat_q[i], {(UW/32){32'(i)}});
  endtask

  task automatic restart();
    rst_n = 1'b0;
    bus.ddr_start = 1'b0;
    step(2);
    cmd_q.delete();
    dat_q.delete();
    valid_cycles = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ddr_start = 1'b0;
    bus.ddr_rdy = 1'b0;
    bus.ddr_wdf_data_rdy = 1'b0;
    bus.ddr_wr_finish = 1'b0;
    step(3);
    chk("rst_cmd_valid", longint'(bus.ddr_cmd_valid), 0);
    chk("rst_wdf_valid", longint'(bus.ddr_wdf_data_valid), 0);
    chk("rst_init_done", longint'(bus.init_done), 0);
    chk("rst_addr", longint'(bus.ddr_base_addr), 0);
    chk("rst_size", longint'(bus.ddr_size), 0);
    chk_w("rst_data", bus.ddr_wdf_data, '0);
    rst_n = 1'b1;

    // Idle with start low, then a command held against a stalled controller.
    step(1000);
    chk("idle_no_valids", longint'(valid_cycles), 0);
    rdy_mode = 2;
    bus.ddr_start = 1'b1;
    step(1);
    chk("start_cmd_valid", longint'(bus.ddr_cmd_valid), 1);
    chk("start_addr", longint'(bus.ddr_base_addr), longint'(BASE));
    chk("start_size", longint'(bus.ddr_size), longint'(BL));
    step(10);
    chk("stall_cmd_valid", longint'(bus.ddr_cmd_valid), 1);
    chk("stall_no_accept", longint'(cmd_q.size()), 0);
    rdy_mode = 0; wdf_mode = 0; fin_delay = 3; fin_rand = 0;
    wait_done(5000);
    check_run("run1");

    // init_done is sticky and ready inputs are ignored afterwards.
    bus.ddr_start = 1'b0;
    rdy_mode = 1; wdf_mode = 2;
    valid_cycles = 0;
    step(100);
    chk("done_sticky", longint'(bus.init_done), 1);
    chk("done_no_valids", longint'(valid_cycles), 0);

    // Random stalls, toggling write-ready, random finish delays, start dropped mid-run.
    restart();
    rdy_mode = 1; wdf_mode = 1; fin_rand = 1;
    bus.ddr_start = 1'b1;
    for (int k = 0; k < 200 && cmd_q.size() == 0; k++) step(1);
    bus.ddr_start = 1'b0;
    wait_done(8000);
    check_run("run2");

    // Finish pulse coincides with the last data handshake of each burst.
    restart();
    rdy_mode = 0; wdf_mode = 2; fin_rand = 0; fin_delay = 0;
    bus.ddr_start = 1'b1;
    wait_done(8000);
    check_run("run3");

    // Reset in the middle of a burst, then a clean restart from word 0.
    restart();
    rdy_mode = 0; wdf_mode = 0; fin_delay = 2;
    bus.ddr_start = 1'b1;
    for (int k = 0; k < 2000 && dat_q.size() < 100; k++) step(1);
    chk("reached_word_100", longint'(dat_q.size() >= 100), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cmd_valid", longint'(bus.ddr_cmd_valid), 0);
    chk("abort_wdf_valid", longint'(bus.ddr_wdf_data_valid), 0);
    chk("abort_size", longint'(bus.ddr_size), 0);
    chk_w("abort_data", bus.ddr_wdf_data, '0);
    step(2);
    cmd_q.delete();
    dat_q.delete();
    rst_n = 1'b1;
    wait_done(5000);
    check_run("run4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
